echo_capture_frame: RTL and testbench
=====================================

Name: echo_capture_frame

Overview:
Parametrised successor of the single-shot echo receiver. After each laser fire strobe it waits a programmable delay, then captures N_SAMPLES consecutive deserialiser words into a frame register and flags frame completion. It sits between the SERDES receive datapath and the echo/distance processing. It adds latched delay, trigger-overrun accounting, abort, a busy flag and an optional peak search.

Parameters:
SAMPLE_W, 16, width of one rx word
N_SAMPLES, 25, words per frame (range 1..255)
DELAY_W, 8, width of delay_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
send_en  in  1  fire strobe, one-cycle pulse expected
abort  in  1  synchronous abort of the current capture
delay_cnt  in  DELAY_W  trigger-to-first-sample delay in cycles
rx_data  in  SAMPLE_W  deserialiser word, new word every clk
frame_data  out  SAMPLE_W*N_SAMPLES  captured frame; sample k at [k*SAMPLE_W +: SAMPLE_W]
frame_valid  out  1  one-cycle pulse: frame_data freshly updated
busy  out  1  high in any state except IDLE
overrun_cnt  out  8  saturating count of ignored triggers
peak_val  out  SAMPLE_W  largest sample of last frame (PEAK_DETECT_EN only)
peak_idx  out  8  index of first occurrence of peak_val (PEAK_DETECT_EN only)

Behaviour:
- Reset (async, rst=0): state IDLE; frame_data, frame_valid, busy, overrun_cnt, peak_val, peak_idx, all counters and the shadow buffer = 0.
- FSM states: IDLE, DELAY, CAPTURE, DONE.
- IDLE: send_en=1 -> latch delay_cnt into dly_q, clear the counters, go to DELAY.
- DELAY: counts dly_q cycles, then enters CAPTURE.
- Timing: with send_en high at edge T and delay D, rx_data is sampled at edges T+1+D through T+D+N_SAMPLES. D=0 samples on the first edge after the trigger.
- CAPTURE: each cycle writes rx_data into shadow slot s, s = 0..N_SAMPLES-1. When s = N_SAMPLES-1 is written, go to DONE.
- DONE (one cycle): copy shadow to frame_data, pulse frame_valid, go to IDLE.
- frame_data changes only in DONE. Frame latency = D+N_SAMPLES+2 edges from trigger to frame_valid.
- A send_en in the DONE cycle itself is counted as an overrun. A send_en in the cycle after DONE starts a new capture.
- busy=1 in DELAY, CAPTURE and DONE.
- Trigger while busy: ignored; overrun_cnt += 1, saturating at 255. The counter clears only on reset.
- abort=1 in any non-IDLE state: next state IDLE; no frame_valid; frame_data holds its previous value; shadow contents are don't-care.
- abort and send_en high together in IDLE: abort wins and the trigger is dropped (not counted).
- delay_cnt changes after the trigger have no effect on the current capture.
- Reset asserted mid-capture: immediate return to reset values; no partial frame is ever output.

Optional Feature:
Macro PEAK_DETECT_EN.
- Defined: a running max is tracked during CAPTURE. Slot 0 initialises it. A later sample replaces it only if strictly greater, so ties keep the lower index. peak_val and peak_idx update in the DONE cycle, together with frame_valid. On abort they keep their previous values.
- Undefined: no compare logic is built; peak_val and peak_idx are tied to 0.

Test Plan:
1. SAMPLE_W=16, N_SAMPLES=25, D=3, rx_data = cycle counter starting at 0x0100 at the trigger edge -> frame_valid exactly 30 edges after the trigger; slot 0 = 0x0104, slot 24 = 0x011C; busy high for 29 cycles.
2. D=0, rx_data = 0xA5A5 constant except 0x7FFF on capture cycles 7 and 12 -> all slots 0xA5A5 except slots 7 and 12 = 0x7FFF; with PEAK_DETECT_EN, peak_val=0xA5A5, peak_idx=0 (unsigned max, first occurrence).
3. Three extra send_en pulses during DELAY/CAPTURE -> one frame only; overrun_cnt=3. Then 300 ignored triggers -> overrun_cnt saturates at 255.
4. abort at capture slot 10 after a completed frame F1 -> no frame_valid; frame_data still equals F1; busy drops the next cycle; the next trigger captures normally.
5. rst pulsed low for 1 cycle mid-CAPTURE -> all outputs 0 immediately; no frame_valid afterwards; a following trigger with D=5 yields frame_valid at edge +32.
6. Back-to-back: second send_en on the cycle after frame_valid -> accepted, no overrun. A send_en coincident with frame_valid -> counted as an overrun.

Source files
------------

// File: rtl/echo_capture_frame.sv
// rtl/echo_capture_frame.sv - delayed multi-sample echo frame capture with overrun accounting; optional peak search under PEAK_DETECT_EN
module echo_capture_frame #(
    parameter int SAMPLE_W  = 16,
    parameter int N_SAMPLES = 25,
    parameter int DELAY_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send_en,
    input  logic                          abort,
    input  logic [DELAY_W-1:0]            delay_cnt,
    input  logic [SAMPLE_W-1:0]           rx_data,
    output logic [SAMPLE_W*N_SAMPLES-1:0] frame_data,
    output logic                          frame_valid,
    output logic                          busy,
    output logic [7:0]                    overrun_cnt,
    output logic [SAMPLE_W-1:0]           peak_val,
    output logic [7:0]                    peak_idx
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_SLOT = 8'(N_SAMPLES - 1);

    state_t                          state_q;
    state_t                          state_d;
    logic [DELAY_W-1:0]              dly_q;
    logic [DELAY_W-1:0]              dly_cnt_q;
    logic [7:0]                      slot_q;
    logic [SAMPLE_W*N_SAMPLES-1:0]   shadow_q;
    logic                            cap_en;
    logic                            start;

    // An accepted trigger: abort in the same IDLE cycle drops it silently
    assign start = (state_q == IDLE) && send_en && !abort;
    assign busy  = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture enable; the final DELAY edge already samples slot 0 so D=0 captures on the first edge after the trigger
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt_q == dly_q) begin
                    cap_en  = 1'b1;
                    state_d = (slot_q == LAST_SLOT) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en  = 1'b1;
                state_d = (slot_q == LAST_SLOT) ? DONE : CAPTURE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cap_en  = 1'b0;
        end
    end

    // Delay/slot counters, shadow buffer, frame publication and overrun counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly_q       <= '0;
            dly_cnt_q   <= '0;
            slot_q      <= '0;
            shadow_q    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (start) begin
                dly_q     <= delay_cnt;
                dly_cnt_q <= '0;
                slot_q    <= '0;
            end
            if ((state_q == DELAY) && (dly_cnt_q != dly_q)) begin
                dly_cnt_q <= dly_cnt_q + DELAY_W'(1);
            end
            if (cap_en) begin
                shadow_q[slot_q*SAMPLE_W +: SAMPLE_W] <= rx_data;
                slot_q                                <= slot_q + 8'd1;
            end
            if ((state_q == DONE) && !abort) begin
                frame_data  <= shadow_q;
                frame_valid <= 1'b1;
            end
            if (send_en && (state_q != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

`ifdef PEAK_DETECT_EN
    logic [SAMPLE_W-1:0] run_max_q;
    logic [7:0]          run_idx_q;

    // Running unsigned max; strict compare keeps the earliest index on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            peak_val  <= '0;
            peak_idx  <= '0;
        end else begin
            if (cap_en && ((slot_q == 8'd0) || (rx_data > run_max_q))) begin
                run_max_q <= rx_data;
                run_idx_q <= slot_q;
            end
            if ((state_q == DONE) && !abort) begin
                peak_val <= run_max_q;
                peak_idx <= run_idx_q;
            end
        end
    end
`else
    assign peak_val = '0;
    assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_echo_capture_frame.sv
// tb/tb_echo_capture_frame.sv - self-checking bench for echo_capture_frame
`timescale 1ns/1ps
module tb_echo_capture_frame;

    localparam int SW = 16;
    localparam int NS = 25;
    localparam int DW = 8;
    localparam int FW = SW * NS;

    logic          clk = 1'b0;
    logic          rst;
    logic          send_en;
    logic          abort;
    logic [DW-1:0] delay_cnt;
    logic [SW-1:0] rx_data;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          busy;
    logic [7:0]    overrun_cnt;
    logic [SW-1:0] peak_val;
    logic [7:0]    peak_idx;

    echo_capture_frame #(.SAMPLE_W(SW), .N_SAMPLES(NS), .DELAY_W(DW)) dut (
        .clk(clk), .rst(rst), .send_en(send_en), .abort(abort),
        .delay_cnt(delay_cnt), .rx_data(rx_data), .frame_data(frame_data),
        .frame_valid(frame_valid), .busy(busy), .overrun_cnt(overrun_cnt),
        .peak_val(peak_val), .peak_idx(peak_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] frame;
        int            edge_no;
        logic [SW-1:0] pv;
        logic [7:0]    pi;
    } exp_t;

    typedef struct {
        int            d;
        int            m;
        int            sa;
        logic [SW-1:0] va;
        int            sb;
        logic [SW-1:0] vb;
        logic [SW-1:0] pv;
        logic [7:0]    pi;
    } vec_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    int            trig_edge = 0;
    int            mode = 0;
    int            busy_cnt = 0;
    int            exp_ovr = 0;
    bit            got_frame = 0;
    logic [FW-1:0] last_frame = '0;

    function automatic logic [SW-1:0] rx_fn(int m, int rel);
        case (m)
            0:       return 16'(32'h100 + rel);
            1:       return ((rel == 8) || (rel == 13)) ? 16'h7FFF : 16'hA5A5;
            2:       return 16'(32'h9000 - 3 * rel);
            3:       return ((rel % 5) == 0) ? 16'hF000 : 16'h0010;
            default: return 16'((rel * 40503) ^ (rel >> 2));
        endcase
    endfunction

    task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        if (frame_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_valid at edge %0d", edge_n);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("frame_edge", FW'(edge_n + 1), FW'(e.edge_no));
                chk("frame_data", frame_data, e.frame);
                chk("peak_val", FW'(peak_val), FW'(e.pv));
                chk("peak_idx", FW'(peak_idx), FW'(e.pi));
                last_frame = e.frame;
                got_frame  = 1;
            end
        end
    endtask

    task automatic cycle();
        rx_data = rx_fn(mode, edge_n + 1 - trig_edge);
        @(posedge clk);
        edge_n++;
        #1;
        busy_cnt += (busy === 1'b1) ? 1 : 0;
        monitor();
    endtask

    task automatic trigger(int d, bit expect_it);
        exp_t          e;
        logic [SW-1:0] v;
        delay_cnt = DW'(d);
        send_en   = 1'b1;
        trig_edge = edge_n + 1;
        got_frame = 0;
        busy_cnt  = 0;
        if (expect_it) begin
            e.frame = '0;
            e.pv    = '0;
            e.pi    = '0;
            for (int k = 0; k < NS; k++) begin
                v = rx_fn(mode, 1 + d + k);
                e.frame[k*SW +: SW] = v;
`ifdef PEAK_DETECT_EN
                if ((k == 0) || (v > e.pv)) begin
                    e.pv = v;
                    e.pi = 8'(k);
                end
`endif
            end
            e.edge_no = trig_edge + d + NS + 2;
            sbq.push_back(e);
        end
        cycle();
        send_en   = 1'b0;
        delay_cnt = ~DW'(d);
    endtask

    task automatic run_until_frame(int budget);
        int n;
        n = 0;
        while (!got_frame && (n < budget)) begin
            cycle();
            n++;
        end
        if (!got_frame) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout act=none exp=frame within %0d cycles", budget);
        end
    endtask

    task automatic run_to_edge(int target);
        int n;
        n = 0;
        while ((edge_n + 1 != target) && (n < 1000)) begin
            cycle();
            n++;
        end
    endtask

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    vec_t vecs[5];

    initial begin
        vecs[0] = '{d: 3,   m: 0, sa: 0, va: 16'h0104, sb: 24, vb: 16'h011C, pv: 16'h011C, pi: 8'd24};
        vecs[1] = '{d: 0,   m: 1, sa: 7, va: 16'h7FFF, sb: 12, vb: 16'h7FFF, pv: 16'hA5A5, pi: 8'd0};
        vecs[2] = '{d: 1,   m: 2, sa: 0, va: 16'h8FFA, sb: 24, vb: 16'h8FB2, pv: 16'h8FFA, pi: 8'd0};
        vecs[3] = '{d: 2,   m: 3, sa: 2, va: 16'hF000, sb: 3,  vb: 16'h0010, pv: 16'hF000, pi: 8'd2};
        vecs[4] = '{d: 255, m: 0, sa: 0, va: 16'h0200, sb: 24, vb: 16'h0218, pv: 16'h0218, pi: 8'd24};

        rst = 1'b0; send_en = 1'b0; abort = 1'b0; delay_cnt = '0; rx_data = '0;
        #1;
        chk("rst_frame_data", frame_data, '0);
        chk("rst_frame_valid", FW'(frame_valid), '0);
        chk("rst_busy", FW'(busy), '0);
        chk("rst_overrun", FW'(overrun_cnt), '0);
        chk("rst_peak", FW'({peak_val, peak_idx}), '0);
        cycle(); cycle();
        rst = 1'b1;
        cycle();

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].m;
            trigger(vecs[i].d, 1);
            run_until_frame(400);
            chk($sformatf("v%0d_busy_cycles", i), FW'(busy_cnt), FW'(vecs[i].d + NS + 1));
            chk($sformatf("v%0d_slot_a", i), FW'(frame_data[vecs[i].sa*SW +: SW]), FW'(vecs[i].va));
            chk($sformatf("v%0d_slot_b", i), FW'(frame_data[vecs[i].sb*SW +: SW]), FW'(vecs[i].vb));
`ifdef PEAK_DETECT_EN
            chk($sformatf("v%0d_peak", i), FW'({peak_val, peak_idx}), FW'({vecs[i].pv, vecs[i].pi}));
`else
            chk($sformatf("v%0d_peak", i), FW'({peak_val, peak_idx}), '0);
`endif
            cycle();
        end

        // Trigger in the DONE cycle is an overrun; trigger in the following cycle is accepted
        mode = 4;
        trigger(0, 1);
        run_to_edge(trig_edge + NS + 1);
        chk("b2b_busy_in_done", FW'(busy), FW'(1));
        send_en = 1'b1;
        cycle();
        send_en = 1'b0;
        exp_ovr = sat(exp_ovr + 1);
        chk("b2b_frame_seen", FW'(got_frame), FW'(1));
        chk("b2b_done_overrun", FW'(overrun_cnt), FW'(exp_ovr));
        trigger(3, 1);
        run_until_frame(400);
        chk("b2b_no_extra_overrun", FW'(overrun_cnt), FW'(exp_ovr));
        cycle();

        // Extra triggers while busy are counted, not started
        trigger(4, 1);
        for (int p = 0; p < 3; p++) begin
            cycle(); cycle(); cycle();
            send_en = 1'b1;
            cycle();
            send_en = 1'b0;
        end
        run_until_frame(400);
        exp_ovr = sat(exp_ovr + 3);
        chk("ovr_three", FW'(overrun_cnt), FW'(exp_ovr));
        for (int r = 0; r < 2; r++) begin
            cycle();
            trigger(255, 1);
            send_en = 1'b1;
            for (int c = 0; c < 150; c++) cycle();
            send_en = 1'b0;
            run_until_frame(400);
            exp_ovr = sat(exp_ovr + 150);
            chk($sformatf("ovr_sat_%0d", r), FW'(overrun_cnt), FW'(exp_ovr));
        end
        cycle();

        // Abort together with a trigger in IDLE drops the trigger
        abort = 1'b1; send_en = 1'b1;
        cycle();
        abort = 1'b0; send_en = 1'b0;
        chk("idle_abort_busy", FW'(busy), '0);
        chk("idle_abort_ovr", FW'(overrun_cnt), FW'(exp_ovr));

        // Abort while slot 10 is being captured
        mode = 0;
        trigger(2, 0);
        run_to_edge(trig_edge + 1 + 2 + 10);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_busy_drop", FW'(busy), '0);
        for (int c = 0; c < 40; c++) cycle();
        chk("abort_frame_held", frame_data, last_frame);
        trigger(1, 1);
        run_until_frame(400);
        cycle();

        // Asynchronous reset in the middle of a capture
        mode = 4;
        trigger(0, 1);
        for (int c = 0; c < 10; c++) cycle();
        rst = 1'b0;
        #1;
        sbq.delete();
        exp_ovr = 0;
        chk("mid_rst_frame_data", frame_data, '0);
        chk("mid_rst_busy", FW'(busy), '0);
        chk("mid_rst_overrun", FW'(overrun_cnt), '0);
        chk("mid_rst_valid_peak", FW'({frame_valid, peak_val, peak_idx}), '0);
        cycle();
        rst = 1'b1;
        for (int c = 0; c < 40; c++) cycle();
        trigger(5, 1);
        run_until_frame(400);
        cycle();
        chk("final_queue_empty", FW'(sbq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
